// File: rtl/wb_order_arbiter_pkg.sv
// Shared constants, unit-id type, write-back record and issue-counter stepping
// for the write-back order arbiter.
package wb_order_arbiter_pkg;

  localparam int NALU      = 3;
  localparam int CNT_W     = 4;
  localparam int CNT_FIRST = 0;
  localparam int CNT_LAST  = 15;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int UNIT_W    = 3;
  localparam int NUM_UNITS = NALU + 1;
  localparam int IDX_W     = $clog2(NUM_UNITS);

  typedef logic [UNIT_W-1:0] unit_t;

  localparam unit_t NO_UNIT  = unit_t'(0);
  localparam unit_t MEM_UNIT = unit_t'(NALU + 1);

  typedef struct packed {
    unit_t             free;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } wb_t;

  // CNT_FIRST is reserved, so the counter wraps from CNT_LAST straight to CNT_FIRST+1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CNT_LAST)) ? CNT_W'(CNT_FIRST + 1) : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_order_arbiter_if.sv
// Result-strobe, flush and write-back signals between the execution units,
// issue stage and the write-back order arbiter.
interface wb_order_arbiter_if;
  import wb_order_arbiter_pkg::*;

  logic                          i_flush;
  logic [CNT_W-1:0]              i_flush_cnt;
  logic [NUM_UNITS-1:0]          i_res_valid;
  logic [NUM_UNITS*CNT_W-1:0]    i_res_cnt;
  logic [NUM_UNITS*REG_W-1:0]    i_res_rd;
  logic [NUM_UNITS*DATA_W-1:0]   i_res_data;
  logic [NUM_UNITS-1:0]          o_res_ready;
  logic [REG_W-1:0]              o_wreg;
  logic [DATA_W-1:0]             o_wdata;
  unit_t                         o_free;
  logic                          o_err;

  modport master (
    output i_flush, i_flush_cnt, i_res_valid, i_res_cnt, i_res_rd, i_res_data,
    input  o_res_ready, o_wreg, o_wdata, o_free, o_err
  );

  modport slave (
    input  i_flush, i_flush_cnt, i_res_valid, i_res_cnt, i_res_rd, i_res_data,
    output o_res_ready, o_wreg, o_wdata, o_free, o_err
  );

endinterface

// File: rtl/wb_order_match.sv
// Combinational selector: finds buffered slots whose cnt equals the expected
// issue counter; lowest index wins and multiple hits are flagged.
module wb_order_match
  import wb_order_arbiter_pkg::*;
(
  input  logic [NUM_UNITS-1:0]       i_full,
  input  logic [NUM_UNITS*CNT_W-1:0] i_cnts,
  input  logic [CNT_W-1:0]           i_expect,
  output logic [NUM_UNITS-1:0]       o_grant,
  output logic [IDX_W-1:0]           o_idx,
  output logic                       o_hit,
  output logic                       o_multi
);

  logic [NUM_UNITS-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_match[k] = i_full[k] && (i_cnts[k*CNT_W +: CNT_W] == i_expect);
    end
  end

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
      end
    end
    o_hit   = |w_match;
    o_multi = (w_match & (w_match - NUM_UNITS'(1))) != '0;
  end

endmodule

// File: rtl/wb_order_arbiter.sv
// Buffers one finished result per execution unit and drains them onto the single
// ROB write-back port strictly in issue-counter order, one per cycle.
module wb_order_arbiter
  import wb_order_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  wb_order_arbiter_if.slave  bus
);

  logic [NUM_UNITS-1:0]       r_full;
  logic [CNT_W-1:0]           r_cnt  [NUM_UNITS];
  logic [REG_W-1:0]           r_rd   [NUM_UNITS];
  logic [DATA_W-1:0]          r_data [NUM_UNITS];
  logic [CNT_W-1:0]           r_expect;
  logic [REG_W-1:0]           r_wreg;
  logic [DATA_W-1:0]          r_wdata;
  unit_t                      r_free;
  logic                       r_err;

  logic [NUM_UNITS*CNT_W-1:0] w_cnts;
  logic [NUM_UNITS-1:0]       w_grant;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_hit;
  logic                       w_multi;
  logic [NUM_UNITS-1:0]       w_capture;

  always_comb begin
    w_cnts = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_cnts[k*CNT_W +: CNT_W] = r_cnt[k];
    end
  end

  assign w_capture = bus.i_res_valid & ~r_full;

  wb_order_match u_match (
    .i_full   (r_full),
    .i_cnts   (w_cnts),
    .i_expect (r_expect),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_hit    (w_hit),
    .o_multi  (w_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= '0;
      r_expect <= CNT_W'(CNT_FIRST + 1);
      r_wreg   <= '0;
      r_wdata  <= '0;
      r_free   <= NO_UNIT;
      r_err    <= 1'b0;
    end else if (bus.i_flush) begin
      // Redirect: everything buffered is wrong-path, and so are same-cycle strobes.
      r_full   <= '0;
      r_expect <= bus.i_flush_cnt;
      r_wreg   <= '0;
      r_free   <= NO_UNIT;
    end else begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (bus.i_res_valid[k]) begin
          if (r_full[k]) begin
            r_err <= 1'b1;
          end else begin
            r_cnt[k]  <= bus.i_res_cnt[k*CNT_W +: CNT_W];
            r_rd[k]   <= bus.i_res_rd[k*REG_W +: REG_W];
            r_data[k] <= bus.i_res_data[k*DATA_W +: DATA_W];
            if (bus.i_res_cnt[k*CNT_W +: CNT_W] == CNT_W'(CNT_FIRST)) begin
              r_err <= 1'b1;
            end
          end
        end
      end

      // A granted slot is full, so it cannot also be capturing this cycle.
      r_full <= (r_full | w_capture) & ~w_grant;

      if (w_hit) begin
        r_free   <= unit_t'(w_idx) + unit_t'(1);
        r_wreg   <= r_rd[w_idx];
        r_wdata  <= r_data[w_idx];
        r_expect <= cnt_next(r_expect);
        if (w_multi) begin
          r_err <= 1'b1;
        end
      end else begin
        r_free <= NO_UNIT;
        r_wreg <= '0;
      end
    end
  end

  assign bus.o_res_ready = ~r_full;
  assign bus.o_wreg      = r_wreg;
  assign bus.o_wdata     = r_wdata;
  assign bus.o_free      = r_free;
  assign bus.o_err       = r_err;

endmodule

// File: tb/tb_wb_order_arbiter.sv
// Directed bench with a write-back scoreboard drained by an independent monitor.
module tb_wb_order_arbiter;
  import wb_order_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  wb_t  exp_q[$];

  wb_order_arbiter_if bus ();

  wb_order_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write-back the DUT presents must be the next queued one.
  always @(negedge clk) begin
    if (!$isunknown(bus.o_free) && bus.o_free != NO_UNIT) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb_unit", 64'(bus.o_free), 64'(NO_UNIT));
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_free",  64'(bus.o_free),  64'(e.free));
        check("wb_wreg",  64'(bus.o_wreg),  64'(e.wreg));
        check("wb_wdata", 64'(bus.o_wdata), 64'(e.wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_res_valid = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic set_res(input int u, input logic [CNT_W-1:0] c,
                         input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.i_res_valid[u]                = 1'b1;
    bus.i_res_cnt[u*CNT_W +: CNT_W]   = c;
    bus.i_res_rd[u*REG_W +: REG_W]    = rd;
    bus.i_res_data[u*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_wb(input int unit, input logic [REG_W-1:0] rd,
                           input logic [DATA_W-1:0] d);
    wb_t e;
    e.free  = unit_t'(unit);
    e.wreg  = rd;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.i_flush     = 1'b0;
    bus.i_flush_cnt = '0;
    bus.i_res_valid = '0;
    bus.i_res_cnt   = '0;
    bus.i_res_rd    = '0;
    bus.i_res_data  = '0;

    // Reset state
    do_reset();
    check("rst_ready", 64'(bus.o_res_ready), 64'(4'b1111));
    check("rst_free",  64'(bus.o_free),  64'd0);
    check("rst_wreg",  64'(bus.o_wreg),  64'd0);
    check("rst_wdata", 64'(bus.o_wdata), 64'd0);
    check("rst_err",   64'(bus.o_err),   64'd0);

    // In-order: unit1 cnt=1
    set_res(0, 4'd1, 5'd5, 32'hA);
    expect_wb(1, 5'd5, 32'hA);
    tick(); clear_in();
    check("inord_lat_free",  64'(bus.o_free), 64'd0);
    check("inord_ready_lo",  64'(bus.o_res_ready), 64'(4'b1110));
    tick();
    check("inord_free",  64'(bus.o_free), 64'd1);
    check("inord_wreg",  64'(bus.o_wreg), 64'd5);
    tick();
    check("inord_idle",  64'(bus.o_free), 64'd0);
    check("inord_idle_wreg", 64'(bus.o_wreg), 64'd0);
    check("inord_ready", 64'(bus.o_res_ready), 64'(4'b1111));

    // Out-of-order: MEM cnt=2 then unit2 cnt=1
    do_reset();
    set_res(3, 4'd2, 5'd7, 32'h22);
    tick(); clear_in();
    set_res(1, 4'd1, 5'd3, 32'h13);
    expect_wb(2, 5'd3, 32'h13);
    expect_wb(4, 5'd7, 32'h22);
    tick(); clear_in();
    check("ooo_wait", 64'(bus.o_free), 64'd0);
    tick();
    check("ooo_first",  64'(bus.o_free), 64'd2);
    tick();
    check("ooo_second", 64'(bus.o_free), 64'(MEM_UNIT));
    check("ooo_wreg",   64'(bus.o_wreg), 64'd7);
    check("ooo_err",    64'(bus.o_err),  64'd0);

    // Wrap: expect=15, then 15 -> 1, cnt 0 never drained
    do_reset();
    bus.i_flush = 1'b1; bus.i_flush_cnt = 4'd15;
    tick(); clear_in();
    set_res(0, 4'd15, 5'd1, 32'hF);
    set_res(1, 4'd1,  5'd2, 32'h1);
    expect_wb(1, 5'd1, 32'hF);
    expect_wb(2, 5'd2, 32'h1);
    tick(); clear_in();
    tick();
    check("wrap_15", 64'(bus.o_free), 64'd1);
    tick();
    check("wrap_1",  64'(bus.o_free), 64'd2);
    set_res(2, 4'd0, 5'd9, 32'hDEAD);
    tick(); clear_in();
    repeat (4) tick();
    check("cnt0_held",  64'(bus.o_res_ready), 64'(4'b1011));
    check("cnt0_err",   64'(bus.o_err), 64'd1);

    // Flush discards slots with cnt 3,4 and a same-cycle strobe
    do_reset();
    set_res(2, 4'd1, 5'd6, 32'h61);
    expect_wb(3, 5'd6, 32'h61);
    tick(); clear_in();
    set_res(0, 4'd3, 5'd10, 32'h30);
    set_res(1, 4'd4, 5'd11, 32'h40);
    tick(); clear_in();
    tick();
    check("pre_flush_ready", 64'(bus.o_res_ready), 64'(4'b1100));
    bus.i_flush = 1'b1; bus.i_flush_cnt = 4'd9;
    set_res(3, 4'd2, 5'd12, 32'h50);
    tick(); clear_in();
    check("flush_ready", 64'(bus.o_res_ready), 64'(4'b1111));
    check("flush_free",  64'(bus.o_free), 64'd0);
    repeat (3) tick();
    set_res(3, 4'd9, 5'd8, 32'h99);
    expect_wb(4, 5'd8, 32'h99);
    tick(); clear_in();
    tick();
    check("post_flush_free", 64'(bus.o_free), 64'(MEM_UNIT));
    check("flush_err", 64'(bus.o_err), 64'd0);

    // Strobe while full: ignored, data kept, sticky error
    do_reset();
    set_res(0, 4'd2, 5'd9, 32'h55);
    tick(); clear_in();
    check("viol_err_before", 64'(bus.o_err), 64'd0);
    set_res(0, 4'd1, 5'd3, 32'h66);
    tick(); clear_in();
    check("viol_err", 64'(bus.o_err), 64'd1);
    set_res(1, 4'd1, 5'd4, 32'h11);
    expect_wb(2, 5'd4, 32'h11);
    expect_wb(1, 5'd9, 32'h55);
    tick(); clear_in();
    tick();
    tick();
    check("viol_kept_data", 64'(bus.o_wdata), 64'h55);
    set_res(3, 4'd7, 5'd1, 32'h77);
    tick(); clear_in();
    check("err_sticky", 64'(bus.o_err), 64'd1);

    // Reset mid-operation discards the buffered MEM result and clears error
    do_reset();
    check("rst_discard_ready", 64'(bus.o_res_ready), 64'(4'b1111));
    check("rst_clears_err",    64'(bus.o_err), 64'd0);

    // Multi-match: lowest index wins, error flagged, loser stays buffered
    set_res(0, 4'd1, 5'd10, 32'hAA);
    set_res(2, 4'd1, 5'd11, 32'hBB);
    expect_wb(1, 5'd10, 32'hAA);
    tick(); clear_in();
    tick();
    check("multi_win", 64'(bus.o_free), 64'd1);
    check("multi_err", 64'(bus.o_err),  64'd1);
    repeat (3) tick();
    check("multi_loser_held", 64'(bus.o_res_ready), 64'(4'b1011));

    begin
      int budget;
      budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
